// File: rtl/sram_window_reader_if.sv
// Bundle between the 2x2 window reader and its neighbours: config, coordinate
// request, SRAM read port and window output.
// Ports: cfg_base/cfg_width/cfg_height, req_valid/req_ready/req_x/req_y,
//        mem_re/mem_addr/mem_data, win_valid/win_ready/win_data/win_err.
// The reader uses the slave modport. The requester, SRAM and consumer side use master.
interface sram_window_reader_if #(
  parameter int ADDR_BITS = 19,
  parameter int DIM_BITS  = 16
) ();
  logic [ADDR_BITS-1:0] cfg_base;
  logic [DIM_BITS-1:0]  cfg_width;
  logic [DIM_BITS-1:0]  cfg_height;

  logic                 req_valid;
  logic                 req_ready;
  logic [DIM_BITS-1:0]  req_x;
  logic [DIM_BITS-1:0]  req_y;

  logic                 mem_re;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_data;

  logic                 win_valid;
  logic                 win_ready;
  logic [31:0]          win_data;
  logic                 win_err;

  modport slave (
    input  cfg_base, cfg_width, cfg_height,
    input  req_valid, req_x, req_y,
    output req_ready,
    output mem_re, mem_addr,
    input  mem_data,
    output win_valid, win_data, win_err,
    input  win_ready
  );

  modport master (
    output cfg_base, cfg_width, cfg_height,
    output req_valid, req_x, req_y,
    input  req_ready,
    input  mem_re, mem_addr,
    output mem_data,
    input  win_valid, win_data, win_err,
    output win_ready
  );
endinterface

// File: rtl/sram_window_reader.sv
// Fetches the 2x2 neighbourhood at (req_x, req_y) with four byte reads and packs it as
// {p11, p10, p01, p00}. The window is valid 6 cycles after accept, or 1 cycle after
// accept for an out-of-range request. The window is held until win_ready.
// req_ready is high only in IDLE, so requests are never queued.
// Ports: clk, aclr (async, active-high), and bus (slave modport of sram_window_reader_if).
// Optional feature: define WINDOW_CLAMP_EN to clamp the right and bottom neighbours
// at the image edge.
module sram_window_reader #(
  parameter int ADDR_BITS = 19,
  parameter int DIM_BITS  = 16
) (
  input  logic                clk,
  input  logic                aclr,
  sram_window_reader_if.slave bus
);

  localparam int PW = 2 * DIM_BITS;
  // The sum is wide enough that the truncation to ADDR_BITS is the only wrap.
  localparam int SW = ((PW > ADDR_BITS) ? PW : ADDR_BITS) + 2;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, OUT} state_t;

  state_t               state_q;
  logic [ADDR_BITS-1:0] a00_q, dx_q, dy_q;
  logic                 req_ready_q;
  logic                 mem_re_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic                 win_valid_q;
  logic [31:0]          win_data_q;
  logic                 win_err_q;

  logic [PW-1:0]        prod_d;
  logic [SW-1:0]        sum_d;
  logic [ADDR_BITS-1:0] a00_d, dx_d, dy_d;
  logic                 oob_d;

  // Window origin and neighbour offsets are evaluated from the live request.
  // They are only meaningful on the accept edge.
  always_comb begin
    prod_d = PW'(bus.req_y) * PW'(bus.cfg_width);
    sum_d  = SW'(bus.cfg_base) + SW'(prod_d) + SW'(bus.req_x);
    a00_d  = sum_d[ADDR_BITS-1:0];
    oob_d  = (bus.req_x >= bus.cfg_width) || (bus.req_y >= bus.cfg_height);
    dx_d   = ADDR_BITS'(1);
    dy_d   = ADDR_BITS'(bus.cfg_width);
`ifdef WINDOW_CLAMP_EN
    // On the last column or row, re-read the border pixel instead of stepping off the image.
    if (bus.req_x == bus.cfg_width - DIM_BITS'(1)) dx_d = '0;
    if (bus.req_y == bus.cfg_height - DIM_BITS'(1)) dy_d = '0;
`endif
  end

  // The coordinates are folded into a00_q at accept. After that, only the origin
  // and the two offsets are needed to walk the window.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= IDLE;
      a00_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      req_ready_q <= 1'b1;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            a00_q       <= a00_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            win_data_q  <= '0;
            if (oob_d) begin
              win_err_q   <= 1'b1;
              win_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              win_err_q  <= 1'b0;
              // The address is registered here so that A00 is on the bus during RD0.
              mem_re_q   <= 1'b1;
              mem_addr_q <= a00_d;
              state_q    <= RD0;
            end
          end
        end
        // Each read state sets up the next address. The data for an address
        // arrives one state later.
        RD0: begin
          mem_addr_q <= a00_q + dx_q;
          state_q    <= RD1;
        end
        RD1: begin
          mem_addr_q       <= a00_q + dy_q;
          win_data_q[7:0]  <= bus.mem_data;
          state_q          <= RD2;
        end
        RD2: begin
          mem_addr_q       <= a00_q + dy_q + dx_q;
          win_data_q[15:8] <= bus.mem_data;
          state_q          <= RD3;
        end
        RD3: begin
          mem_re_q          <= 1'b0;
          mem_addr_q        <= '0;
          win_data_q[23:16] <= bus.mem_data;
          state_q           <= CAP;
        end
        CAP: begin
          win_data_q[31:24] <= bus.mem_data;
          win_valid_q       <= 1'b1;
          state_q           <= OUT;
        end
        OUT: begin
          if (bus.win_ready) begin
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          mem_re_q    <= 1'b0;
          mem_addr_q  <= '0;
          win_valid_q <= 1'b0;
          win_data_q  <= '0;
          win_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_data_q;
  assign bus.win_err   = win_err_q;

endmodule

// File: tb/tb_sram_window_reader.sv
// Self-checking bench for sram_window_reader. It runs directed cases (basic, corner,
// out-of-range, backpressure, mid-operation reset, address wrap) and randomized
// requests against an arithmetic window model.
module tb_sram_window_reader;
  localparam int AB = 19;
  localparam int DB = 16;

  logic clk;
  logic aclr;

  sram_window_reader_if #(.ADDR_BITS(AB), .DIM_BITS(DB)) bus ();

  sram_window_reader #(.ADDR_BITS(AB), .DIM_BITS(DB)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int mem_mode = 0;

  longint cfg_b, cfg_w, cfg_h;
  logic [31:0]   last_data;
  logic [AB-1:0] exp_addr [4];
  logic          exp_err;
  logic [31:0]   exp_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1, "watchdog");
  end

  // SRAM contents: mode 0 stores each address's low byte, mode 1 stores a scrambled value.
  function automatic logic [7:0] pix(input logic [AB-1:0] a);
    logic [AB-1:0] t;
    if (mem_mode == 0) return a[7:0];
    t = a * AB'(7) + (a >> 5);
    return t[7:0] ^ 8'h5A;
  endfunction

  // The SRAM has a 1-cycle registered read.
  always @(posedge clk) bus.mem_data <= pix(bus.mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input longint b, input longint w, input longint h);
    @(negedge clk);
    cfg_b = b; cfg_w = w; cfg_h = h;
    bus.cfg_base   = AB'(b);
    bus.cfg_width  = DB'(w);
    bus.cfg_height = DB'(h);
  endtask

  // Reference model: origin, neighbour offsets and the packed window by plain arithmetic.
  task automatic model(input longint x, input longint y);
    longint m, a00, dx, dy;
    m   = longint'(1) << AB;
    exp_err = (x >= cfg_w) || (y >= cfg_h);
    a00 = (cfg_b + y * cfg_w + x) % m;
    dx  = 1;
    dy  = cfg_w;
`ifdef WINDOW_CLAMP_EN
    if (x == cfg_w - 1) dx = 0;
    if (y == cfg_h - 1) dy = 0;
`endif
    exp_addr[0] = AB'(a00 % m);
    exp_addr[1] = AB'((a00 + dx) % m);
    exp_addr[2] = AB'((a00 + dy) % m);
    exp_addr[3] = AB'((a00 + dy + dx) % m);
    if (exp_err) exp_data = 32'h0;
    else exp_data = {pix(exp_addr[3]), pix(exp_addr[2]), pix(exp_addr[1]), pix(exp_addr[0])};
  endtask

  // Issue one request, check the read sequence and latency, stall for `hold` cycles,
  // then complete the transfer.
  task automatic run_req(input int x, input int y, input int hold);
    int cyc, nrd, n;
    logic [31:0] held;
    model(longint'(x), longint'(y));
    @(negedge clk);
    bus.req_x = DB'(x);
    bus.req_y = DB'(y);
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);  // accept edge, cycle 0
    #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    nrd = 0;
    while (bus.win_valid !== 1'b1 && cyc < 20) begin
      if (bus.mem_re === 1'b1) begin
        if (nrd < 4) begin
          check("rd_addr", 64'(bus.mem_addr), 64'(exp_addr[nrd]));
          check("rd_cycle", 64'(cyc), 64'(nrd + 1));
        end
        nrd++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (bus.win_valid !== 1'b1) begin
      check("valid_timeout", 0, 1);
      return;
    end
    check("valid_cycle", 64'(cyc), exp_err ? 64'd1 : 64'd6);
    check("read_count", 64'(nrd), exp_err ? 64'd0 : 64'd4);
    check("win_data", 64'(bus.win_data), 64'(exp_data));
    check("win_err", 64'(bus.win_err), 64'(exp_err));
    check("ready_in_out", 64'(bus.req_ready), 0);
    check("re_in_out", 64'(bus.mem_re), 0);
    last_data = bus.win_data;
    held = bus.win_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 64'(bus.win_valid), 1);
      check("bp_data", 64'(bus.win_data), 64'(held));
      check("bp_ready", 64'(bus.req_ready), 0);
    end
    bus.win_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.win_ready = 1'b0;
    check("post_valid", 64'(bus.win_valid), 0);
    check("post_ready", 64'(bus.req_ready), 1);
  endtask

  initial begin
    int seen;
    int w, h, x, y;
    bus.cfg_base = '0; bus.cfg_width = '0; bus.cfg_height = '0;
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0;
    bus.win_ready = 1'b0;
    aclr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 1);
    check("rst_win_valid", 64'(bus.win_valid), 0);
    check("rst_win_data", 64'(bus.win_data), 0);
    check("rst_win_err", 64'(bus.win_err), 0);
    check("rst_mem_re", 64'(bus.mem_re), 0);
    check("rst_mem_addr", 64'(bus.mem_addr), 0);
    @(negedge clk);
    aclr = 1'b0;

    // Directed cases on a 4x4 image at base 0x100, with each pixel equal to its address low byte.
    mem_mode = 0;
    set_cfg(64'h100, 4, 4);
    run_req(1, 1, 0);
    check("basic_const", 64'(last_data), 64'h0A090605);
    run_req(3, 3, 0);
`ifdef WINDOW_CLAMP_EN
    check("corner_const", 64'(last_data), 64'h0F0F0F0F);
`else
    check("corner_const", 64'(last_data), 64'h1413100F);
`endif
    run_req(4, 0, 0);
    check("oob_const", 64'(last_data), 64'h0);
    run_req(1, 1, 10);

    // Reset asserted while the block is in RD2.
    @(negedge clk);
    bus.req_x = DB'(1); bus.req_y = DB'(1); bus.req_valid = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0;  // RD0
    @(posedge clk); #1;                        // RD1
    @(posedge clk); #1;                        // RD2
    check("rd2_mem_re", 64'(bus.mem_re), 1);
    aclr = 1'b1;
    #1;
    check("abort_mem_re", 64'(bus.mem_re), 0);
    check("abort_mem_addr", 64'(bus.mem_addr), 0);
    check("abort_req_ready", 64'(bus.req_ready), 1);
    check("abort_win_valid", 64'(bus.win_valid), 0);
    @(posedge clk);
    @(negedge clk);
    aclr = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.win_valid === 1'b1) seen++;
    end
    check("abort_no_window", 64'(seen), 0);
    run_req(1, 1, 0);
    check("rst_fresh_const", 64'(last_data), 64'h0A090605);

    // The window origin sits at the top of the address space, so the reads wrap.
    set_cfg(64'h7FFFF, 4, 2);
    run_req(0, 0, 0);

    // Randomized requests over small images, with some out of range.
    mem_mode = 1;
    for (int k = 0; k < 40; k++) begin
      w = int'($urandom_range(1, 9));
      h = int'($urandom_range(1, 9));
      set_cfg(longint'($urandom & 32'h7FFFF), longint'(w), longint'(h));
      x = int'($urandom_range(0, w));
      y = int'($urandom_range(0, h));
      run_req(x, y, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_window_reader.md
# sram_window_reader

Read engine that fetches the 2x2 pixel neighbourhood needed by one bilinear-downscale output sample from the shared 8-bit SRAM. It issues four sequential byte reads, packs them into one 32-bit window and hands it downstream over valid/ready. It sits between the downscale datapath and the SRAM port that the control unit owns while busy. Arbitration of that port is external.

## Interface
- `ADDR_BITS`, 19: SRAM byte-address width.
- `DIM_BITS`, 16: width of coordinates and image dimensions.

Ports:
- `clk` in 1: sole clock.
- `aclr` in 1: reset, asynchronous, active-high.
- `cfg_base` in ADDR_BITS: byte address of source pixel (0,0).
- `cfg_width` in DIM_BITS: row stride and image width, in pixels.
- `cfg_height` in DIM_BITS: image height.
- `req_valid` in 1: coordinate request.
- `req_ready` out 1: high only in IDLE.
- `req_x`, `req_y` in DIM_BITS: top-left pixel of the window.
- `mem_re` out 1: read strobe, for arbiter/debug; the SRAM reads on address alone.
- `mem_addr` out ADDR_BITS: SRAM byte address.
- `mem_data` in 8: SRAM read data, valid one cycle after `mem_addr`.
- `win_valid` out 1: window available.
- `win_ready` in 1: downstream accepts the window.
- `win_data` out 32: packed as {p11, p10, p01, p00}, with p00 in bits [7:0].
- `win_err` out 1: the request was out of range.

## Operation
- FSM states: IDLE, RD0, RD1, RD2, RD3, CAP, OUT.
- IDLE, on `req_valid && req_ready` (accept edge):
  - Register x and y.
  - Compute A00 = cfg_base + req_y*cfg_width + req_x. The product is formed at 2*DIM_BITS, then the sum is truncated mod 2^ADDR_BITS.
  - Set dx = 1 and dy = cfg_width.
  - If `req_x >= cfg_width` or `req_y >= cfg_height`, go to OUT with win_err=1 and win_data=0. Otherwise go to RD0.
- Read addresses, one state each, with `mem_re`=1:
  - RD0: `mem_addr` = A00.
  - RD1: A01 = A00+dx.
  - RD2: A10 = A00+dy.
  - RD3: A11 = A10+dx.
  - All sums are taken mod 2^ADDR_BITS, so the address wraps.
- Data capture: the end of RD1 captures p00, RD2 captures p01, RD3 captures p10, and CAP captures p11. In CAP, `mem_re`=0.
- OUT: `win_valid`=1. Hold `win_data` and `win_err` until `win_ready`, then return to IDLE.
- In CAP, OUT and IDLE, `mem_addr` is 0 and `mem_re` is 0.
- `cfg_*` inputs are sampled at accept and must stay stable while not in IDLE. The block does not check this.
- A request with `req_valid` arriving during OUT waits. There is no request queueing.

## Timing
- Reset values: state IDLE; `req_ready`=1; `win_valid`=0; `win_data`=0; `win_err`=0; `mem_re`=0; `mem_addr`=0.
- `aclr` mid-operation aborts immediately and returns to IDLE. No partial window is ever presented.
- Latency, in-range request: the accept edge is cycle 0, RD0–RD3 occupy cycles 1–4, CAP is cycle 5, and `win_valid` is high from cycle 6.
- Latency, out-of-range request: `win_valid` is high from cycle 1.
- Throughput: one window per 7 cycles with `win_ready` held high.
- `req_ready` returns to 1 in the cycle after the `win_valid && win_ready` edge.
- `mem_data` is sampled exactly one cycle after the matching address. This assumes an SRAM with 1-cycle registered read.

## Configuration
- `WINDOW_CLAMP_EN` defined (edge clamping on):
  - If x == cfg_width-1, then dx = 0.
  - If y == cfg_height-1, then dy = 0.
  - Edge windows therefore replicate the border pixels.
- `WINDOW_CLAMP_EN` undefined: dx=1 and dy=cfg_width always. Reads at the edge fall into the next row or past the image end. The caller is responsible for this.

## Test plan
- **Basic window.** Setup: base=0x100, width=4, height=4, memory byte = addr[7:0]. Request (1,1). Required:
  - Reads of 0x105, 0x106, 0x109, 0x10A on cycles 1–4.
  - `win_valid` high at cycle 6 with `win_data`=0x0A090605 and `win_err`=0.
- **Corner request (3,3), same setup.**
  - With `WINDOW_CLAMP_EN`: address 0x10F four times and `win_data`=0x0F0F0F0F.
  - Without it: reads of 0x10F, 0x110, 0x113, 0x114 and `win_data`=0x1413100F.
- **Out of range.** Request (4,0) with width=4. Required: `mem_re` never asserts, `win_valid` is high at cycle 1, `win_err`=1, `win_data`=0.
- **Backpressure.** Hold `win_ready`=0 for 10 cycles after `win_valid`. Required: `win_data` stays stable and `req_ready` stays 0. On release there is exactly one transfer, and `req_ready` is 1 the next cycle.
- **Reset mid-operation.** Assert `aclr` during RD2. Required: `mem_re`=0 and state IDLE immediately, and `win_valid` never asserts. A fresh request (1,1) after release yields 0x0A090605.
- **Address wrap.** base=0x7FFFF, width=4, height=2, request (0,0). Required: reads of 0x7FFFF, 0x00000, 0x00003, 0x00004.
